mult_div_unit: RTL and testbench

//  Multi-cycle multiply/divide unit with HI/LO registers, placed beside the ALU in the execute stage.
//  It takes GPR[rs] and GPR[rt] (BusA/BusB) from the register file read ports.
//  It supplies HI and LO to the write-back mux for mfhi/mflo.

---
 rtl/mult_div_unit_if.sv | 23 ++
 rtl/mult_div_unit.sv | 137 +++++++++++++
 tb/tb_mult_div_unit.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Handshake and data bundle between the execute stage and the
// multiply/divide unit.
interface mult_div_unit_if;
   logic        start;
   logic [1:0]  md_op;
   logic        wr_hi;
   logic        wr_lo;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output start, md_op, wr_hi, wr_lo, A, B,
      input  busy, HI, LO
   );

   modport slave (
      input  start, md_op, wr_hi, wr_lo, A, B,
      output busy, HI, LO
   );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle mult/multu/div/divu unit with HI/LO registers.
// Result is computed at start and released after a fixed latency.
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic             clk,
   input logic             reset,
   mult_div_unit_if.slave  bus
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                         MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic [31:0]     r_hi, w_hi_nxt;
   logic [31:0]     r_lo, w_lo_nxt;
   logic [31:0]     r_pend_hi, w_pend_hi_nxt;
   logic [31:0]     r_pend_lo, w_pend_lo_nxt;
   logic            r_pend_ok, w_pend_ok_nxt;

   logic signed [63:0] w_sa64, w_sb64, w_sprod;
   logic [63:0]        w_uprod;
   logic               w_bzero, w_ovf;
   logic [31:0]        w_udvs, w_uq, w_ur;
   logic signed [31:0] w_sa, w_sdvs, w_sq, w_sr;
   logic [31:0]        w_res_hi, w_res_lo;
   logic [CW-1:0]      w_n;

   assign w_sa64  = {{32{bus.A[31]}}, bus.A};
   assign w_sb64  = {{32{bus.B[31]}}, bus.B};
   assign w_sprod = w_sa64 * w_sb64;
   assign w_uprod = {32'd0, bus.A} * {32'd0, bus.B};

   // Zero divisor and INT_MIN/-1 both divide by 1: the former is
   // discarded, the latter yields exactly q=INT_MIN, r=0.
   assign w_bzero = (bus.B == 32'd0);
   assign w_ovf   = (bus.A == 32'h8000_0000) &&
                    (bus.B == 32'hFFFF_FFFF);
   assign w_udvs  = w_bzero ? 32'd1 : bus.B;
   assign w_sa    = bus.A;
   assign w_sdvs  = (w_bzero || w_ovf) ? 32'sd1 : bus.B;
   assign w_sq    = w_sa / w_sdvs;
   assign w_sr    = w_sa % w_sdvs;
   assign w_uq    = bus.A / w_udvs;
   assign w_ur    = bus.A % w_udvs;

   assign w_n = bus.md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

   always_comb begin
      w_res_hi = 32'd0;
      w_res_lo = 32'd0;
      unique case (bus.md_op)
         2'd0: begin
            w_res_hi = w_sprod[63:32];
            w_res_lo = w_sprod[31:0];
         end
         2'd1: begin
            w_res_hi = w_uprod[63:32];
            w_res_lo = w_uprod[31:0];
         end
         2'd2: begin
            w_res_hi = w_sr;
            w_res_lo = w_sq;
         end
         2'd3: begin
            w_res_hi = w_ur;
            w_res_lo = w_uq;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_hi_nxt      = r_hi;
      w_lo_nxt      = r_lo;
      w_pend_hi_nxt = r_pend_hi;
      w_pend_lo_nxt = r_pend_lo;
      w_pend_ok_nxt = r_pend_ok;
      unique case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_pend_hi_nxt = w_res_hi;
               w_pend_lo_nxt = w_res_lo;
               w_pend_ok_nxt = !(bus.md_op[1] && w_bzero);
               w_cnt_nxt     = w_n;
               w_state_nxt   = S_BUSY;
            end else begin
               if (bus.wr_hi) w_hi_nxt = bus.A;
               if (bus.wr_lo) w_lo_nxt = bus.A;
            end
         end
         S_BUSY: begin
            w_cnt_nxt = r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
               w_state_nxt = S_IDLE;
               if (r_pend_ok) begin
                  w_hi_nxt = r_pend_hi;
                  w_lo_nxt = r_pend_lo;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
         r_pend_hi <= 32'd0;
         r_pend_lo <= 32'd0;
         r_pend_ok <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_hi      <= w_hi_nxt;
         r_lo      <= w_lo_nxt;
         r_pend_hi <= w_pend_hi_nxt;
         r_pend_lo <= w_pend_lo_nxt;
         r_pend_ok <= w_pend_ok_nxt;
      end
   end

   assign bus.busy = (r_state == S_BUSY);
   assign bus.HI   = r_hi;
   assign bus.LO   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases with literal results plus
// random traffic checked every cycle against an arithmetic model.
module tb_mult_div_unit;
   localparam int MC = 5;
   localparam int DC = 10;

   logic clk;
   logic reset;
   mult_div_unit_if bus ();

   mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h want %08h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Reference results from plain integer arithmetic.
   function automatic void calc(input logic [1:0] op,
                                input logic [31:0] a, b,
                                output logic [31:0] hi, lo,
                                output bit ok);
      int                si_a, si_b;
      longint            sa, sb, sp, sq, sr;
      longint unsigned   ua, ub, up;
      si_a = a;
      si_b = b;
      sa = si_a;
      sb = si_b;
      ua = {32'd0, a};
      ub = {32'd0, b};
      ok = 1'b1;
      hi = 32'd0;
      lo = 32'd0;
      case (op)
         2'd0: begin
            sp = sa * sb;
            hi = sp[63:32];
            lo = sp[31:0];
         end
         2'd1: begin
            up = ua * ub;
            hi = up[63:32];
            lo = up[31:0];
         end
         2'd2: begin
            if (b == 32'd0) ok = 1'b0;
            else begin
               sq = sa / sb;
               sr = sa % sb;
               hi = sr[31:0];
               lo = sq[31:0];
            end
         end
         default: begin
            if (b == 32'd0) ok = 1'b0;
            else begin
               hi = 32'(ua % ub);
               lo = 32'(ua / ub);
            end
         end
      endcase
   endfunction

   logic [31:0] e_hi, e_lo, p_hi, p_lo;
   bit          p_ok;
   int          rem;

   always @(posedge clk) begin
      if (reset) begin
         e_hi = 32'd0;
         e_lo = 32'd0;
         rem  = 0;
      end else if (rem > 0) begin
         rem = rem - 1;
         if (rem == 0 && p_ok) begin
            e_hi = p_hi;
            e_lo = p_lo;
         end
      end else if (bus.start) begin
         calc(bus.md_op, bus.A, bus.B, p_hi, p_lo, p_ok);
         rem = bus.md_op[1] ? DC : MC;
      end else begin
         if (bus.wr_hi) e_hi = bus.A;
         if (bus.wr_lo) e_lo = bus.A;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("cyc_busy", {31'd0, bus.busy}, {31'd0, rem > 0});
         chk("cyc_hi", bus.HI, e_hi);
         chk("cyc_lo", bus.LO, e_lo);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [1:0] op,
                         input logic [31:0] a, b,
                         input bit with_wrhi, input bit inject,
                         output int n);
      bus.start = 1'b1;
      bus.md_op = op;
      bus.A     = a;
      bus.B     = b;
      bus.wr_hi = with_wrhi;
      bus.wr_lo = 1'b0;
      tick();
      bus.start = 1'b0;
      bus.wr_hi = 1'b0;
      n = 0;
      while (bus.busy && n < 100) begin
         if (inject && n == 2) begin
            bus.start = 1'b1;
            bus.md_op = 2'd0;
            bus.wr_lo = 1'b1;
            bus.A     = 32'h0000_AAAA;
         end else begin
            bus.start = 1'b0;
            bus.wr_lo = 1'b0;
         end
         tick();
         n++;
      end
      bus.start = 1'b0;
      bus.wr_lo = 1'b0;
   endtask

   int n;
   logic [31:0] rb;

   initial begin
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.md_op = 2'd0;
      bus.wr_hi = 1'b0;
      bus.wr_lo = 1'b0;
      bus.A     = 32'd0;
      bus.B     = 32'd0;
      tick();
      chk_on = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_hi", bus.HI, 32'd0);
      chk("rst_lo", bus.LO, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);

      run_op(2'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, n);
      chk("mult_cyc", n, MC);
      chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
      chk("mult_lo", bus.LO, 32'hFFFF_FFFA);

      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, n);
      chk("multu_cyc", n, MC);
      chk("multu_hi", bus.HI, 32'hFFFF_FFFE);
      chk("multu_lo", bus.LO, 32'h0000_0001);

      run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, n);
      chk("div_cyc", n, DC);
      chk("div_lo", bus.LO, 32'hFFFF_FFFD);
      chk("div_hi", bus.HI, 32'hFFFF_FFFF);

      run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, n);
      chk("divu_lo", bus.LO, 32'h7FFF_FFFC);
      chk("divu_hi", bus.HI, 32'h0000_0001);

      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, n);
      chk("ovf_lo", bus.LO, 32'h8000_0000);
      chk("ovf_hi", bus.HI, 32'd0);

      bus.wr_hi = 1'b1;
      bus.A     = 32'h0000_1234;
      tick();
      bus.wr_hi = 1'b0;
      bus.wr_lo = 1'b1;
      bus.A     = 32'h0000_5678;
      tick();
      bus.wr_lo = 1'b0;
      chk("mthi", bus.HI, 32'h0000_1234);
      chk("mtlo", bus.LO, 32'h0000_5678);
      bus.wr_hi = 1'b1;
      bus.wr_lo = 1'b1;
      bus.A     = 32'h0000_9999;
      tick();
      bus.wr_hi = 1'b0;
      bus.wr_lo = 1'b0;
      chk("mt_both_hi", bus.HI, 32'h0000_9999);
      chk("mt_both_lo", bus.LO, 32'h0000_9999);

      run_op(2'd0, 32'd5, 32'd7, 1'b1, 1'b0, n);
      chk("start_wrhi_hi", bus.HI, 32'd0);
      chk("start_wrhi_lo", bus.LO, 32'd35);

      run_op(2'd2, 32'd100, 32'd7, 1'b0, 1'b1, n);
      chk("inject_cyc", n, DC);
      chk("inject_lo", bus.LO, 32'd14);
      chk("inject_hi", bus.HI, 32'd2);

      run_op(2'd3, 32'd55, 32'd0, 1'b0, 1'b0, n);
      chk("dz_cyc", n, DC);
      chk("dz_lo", bus.LO, 32'd14);
      chk("dz_hi", bus.HI, 32'd2);

      bus.start = 1'b1;
      bus.md_op = 2'd2;
      bus.A     = 32'd50;
      bus.B     = 32'd3;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_hi", bus.HI, 32'd0);
      chk("abort_lo", bus.LO, 32'd0);
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);

      run_op(2'd0, 32'd3, 32'd4, 1'b0, 1'b0, n);
      chk("b2b_lo1", bus.LO, 32'd12);
      run_op(2'd1, 32'h0000_FFFF, 32'h0001_0001, 1'b0, 1'b0, n);
      chk("b2b_cyc", n, MC);
      chk("b2b_hi", bus.HI, 32'd0);
      chk("b2b_lo", bus.LO, 32'hFFFF_FFFF);

      for (int i = 0; i < 800; i++) begin
         bus.start = ($urandom_range(0, 3) == 0);
         bus.md_op = 2'($urandom_range(0, 3));
         bus.wr_hi = ($urandom_range(0, 2) == 0);
         bus.wr_lo = ($urandom_range(0, 2) == 0);
         bus.A     = ($urandom_range(0, 7) == 0) ?
                     32'h8000_0000 : $urandom;
         case ($urandom_range(0, 4))
            0: rb = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            2: rb = 32'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         bus.B = rb;
         reset = ($urandom_range(0, 149) == 0);
         tick();
      end
      reset     = 1'b0;
      bus.start = 1'b0;
      bus.wr_hi = 1'b0;
      bus.wr_lo = 1'b0;
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
